axi_burst_master: RTL and testbench

Parametrised successor to the single-beat AXI master. Accepts one request per transaction from the internal bus and executes it as an AXI4 INCR burst of 1..MAX_BEATS beats, with narrow-transfer lane steering. Write data and read data are carried on valid/ready streams, so burst length is not limited by an internal buffer. Sits between the core-side load/store/DMA logic and the AXI interconnect; one transaction is in flight at a time.

---
 rtl/axi_pkg.sv | 33 +++
 rtl/axi_lane_steer.sv | 26 ++
 rtl/axi_burst_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state encoding and response helper
// for the burst master and its lane steering unit.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR       = 2'b01;
   localparam logic [3:0] CACHE_BUFFERABLE = 4'b0011;
   localparam logic [2:0] PROT_UNPRIV      = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REJ,
      ST_AW,
      ST_W,
      ST_B,
      ST_AR,
      ST_R,
      ST_DONE
   } state_e;

   // Response codes are numbered in rising severity, so worst-of is max.
   function automatic logic [1:0] resp_worst(
      input logic [1:0] a,
      input logic [1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_lane_steer.sv
// Byte-lane steering for narrow beats: strobe mask and bit shift
// derived from the beat size and the low bits of the lane address.
module axi_lane_steer #(
   parameter int DATA_W = 64
) (
   input  logic [2:0]                      size_i,
   input  logic [$clog2(DATA_W/8)-1:0]     off_i,
   output logic [DATA_W/8-1:0]             strb_o,
   output logic [$clog2(DATA_W/8)+2:0]     shamt_o
);

   localparam int STRB_W = DATA_W / 8;

   logic [STRB_W-1:0] mask;

   // Build a 1<<size byte mask at lane 0, then move it to the beat lane.
   always_comb begin
      mask = '0;
      for (int i = 0; i < STRB_W; i++) begin
         mask[i] = (i < (1 << size_i));
      end
      strb_o  = mask << off_i;
      shamt_o = {off_i, 3'b000};
   end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst master: one request in flight, streamed W/R beats,
// narrow-transfer lane steering and worst-of response reporting.
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int MAX_BEATS = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_write,
   input  logic [ADDR_W-1:0]     i_req_addr,
   input  logic [7:0]            i_req_len,
   input  logic [2:0]            i_req_size,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   output logic [DATA_W-1:0]     o_rdata,
   output logic                  o_rvalid,
   input  logic                  i_rready,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic                  o_invalid,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wlast,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   input  logic [1:0]            m_axi_bresp,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   input  logic [DATA_W-1:0]     m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast
);

   localparam int         STRB_W   = DATA_W / 8;
   localparam int         OFF_W    = $clog2(STRB_W);
   localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] lane_q, lane_d;
   logic [7:0]        len_q, len_d;
   logic [2:0]        size_q, size_d;
   logic [7:0]        beat_q, beat_d;
   logic [1:0]        acc_q, acc_d;

   logic [16:0]       span;
   logic [16:0]       reach;
   logic [ADDR_W-1:0] amask;
   logic              reject;
   logic              last;
   logic [ADDR_W-1:0] step;
   logic [STRB_W-1:0] strb;
   logic [OFF_W+2:0]  shamt;

   axi_lane_steer #(
      .DATA_W (DATA_W)
   ) u_steer (
      .size_i  (size_q),
      .off_i   (lane_q[OFF_W-1:0]),
      .strb_o  (strb),
      .shamt_o (shamt)
   );

   assign last = (beat_q == len_q);
   assign step = ADDR_W'(1) << size_q;

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = len_q;
   assign m_axi_awsize  = size_q;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awcache = CACHE_BUFFERABLE;
   assign m_axi_awprot  = PROT_UNPRIV;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_arsize  = size_q;
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arcache = CACHE_BUFFERABLE;
   assign m_axi_arprot  = PROT_UNPRIV;

   assign m_axi_wdata = i_wdata << shamt;
   assign m_axi_wstrb = strb;
   assign m_axi_wlast = last;
   assign o_rdata     = m_axi_rdata >> shamt;
   assign o_busy      = (state_q != ST_IDLE);

   // Screen the incoming request: size, alignment, length and 4 KB span.
   always_comb begin
      span   = 17'({1'b0, i_req_len} + 9'd1) << i_req_size;
      reach  = {5'd0, i_req_addr[11:0]} + span;
      amask  = (ADDR_W'(1) << i_req_size) - ADDR_W'(1);
      reject = (i_req_size > MAX_SIZE)
            || (|(i_req_addr & amask))
            || ({1'b0, i_req_len} >= 9'(MAX_BEATS))
            || (reach > 17'd4096);
   end

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      lane_d        = lane_q;
      len_d         = len_q;
      size_d        = size_q;
      beat_d        = beat_q;
      acc_d         = acc_q;
      o_req_ready   = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      o_wready      = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_rready  = 1'b0;
      o_rvalid      = 1'b0;
      o_done        = 1'b0;
      o_error       = 1'b0;
      o_invalid     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               addr_d = i_req_addr;
               lane_d = i_req_addr;
               len_d  = i_req_len;
               size_d = i_req_size;
               beat_d = '0;
               acc_d  = RESP_OKAY;
               if (reject) begin
                  state_d = ST_REJ;
               end else if (i_req_write) begin
                  state_d = ST_AW;
               end else begin
                  state_d = ST_AR;
               end
            end
         end
         ST_REJ: begin
            o_done    = 1'b1;
            o_error   = 1'b1;
            o_invalid = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_AW: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) begin
               state_d = ST_W;
            end
         end
         ST_W: begin
            m_axi_wvalid = i_wvalid;
            o_wready     = m_axi_wready;
            if (i_wvalid && m_axi_wready) begin
               lane_d = lane_q + step;
               if (last) begin
                  state_d = ST_B;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         ST_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               acc_d   = resp_worst(acc_q, m_axi_bresp);
               state_d = ST_DONE;
            end
         end
         ST_AR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) begin
               state_d = ST_R;
            end
         end
         ST_R: begin
            m_axi_rready = i_rready;
            o_rvalid     = m_axi_rvalid;
            if (m_axi_rvalid && i_rready) begin
               acc_d  = resp_worst(acc_q, m_axi_rresp);
               if (m_axi_rlast != last) begin
                  acc_d = RESP_SLVERR;
               end
               lane_d = lane_q + step;
               if (last) begin
                  state_d = ST_DONE;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         ST_DONE: begin
            o_done    = 1'b1;
            o_error   = (acc_q != RESP_OKAY);
            o_invalid = (acc_q == RESP_DECERR);
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and transaction registers, synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         lane_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         beat_q  <= '0;
         acc_q   <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         len_q   <= len_d;
         size_q  <= size_d;
         beat_q  <= beat_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: behavioural AXI slave,
// directed scenarios followed by randomized transactions.
module tb_axi_burst_master;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 64;
   localparam int MAX_BEATS = 16;
   localparam int STRB_W    = DATA_W / 8;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   logic              i_req_valid, o_req_ready, i_req_write;
   logic [31:0]       i_req_addr;
   logic [7:0]        i_req_len;
   logic [2:0]        i_req_size;
   logic [63:0]       i_wdata, o_rdata;
   logic              i_wvalid, o_wready, o_rvalid, i_rready;
   logic              o_busy, o_done, o_error, o_invalid;
   logic              m_axi_awvalid, m_axi_awready;
   logic [31:0]       m_axi_awaddr;
   logic [7:0]        m_axi_awlen;
   logic [2:0]        m_axi_awsize;
   logic [1:0]        m_axi_awburst;
   logic [3:0]        m_axi_awcache;
   logic [2:0]        m_axi_awprot;
   logic              m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic [63:0]       m_axi_wdata;
   logic [7:0]        m_axi_wstrb;
   logic              m_axi_bvalid, m_axi_bready;
   logic [1:0]        m_axi_bresp;
   logic              m_axi_arvalid, m_axi_arready;
   logic [31:0]       m_axi_araddr;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic [1:0]        m_axi_arburst;
   logic [3:0]        m_axi_arcache;
   logic [2:0]        m_axi_arprot;
   logic              m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [63:0]       m_axi_rdata;
   logic [1:0]        m_axi_rresp;

   axi_burst_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_write(i_req_write), .i_req_addr(i_req_addr),
      .i_req_len(i_req_len), .i_req_size(i_req_size),
      .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_rdata(o_rdata), .o_rvalid(o_rvalid), .i_rready(i_rready),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .o_invalid(o_invalid),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_bresp(m_axi_bresp),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast)
   );

   int checks = 0;
   int errors = 0;

   logic [1:0] cfg_bresp;
   logic [1:0] cfg_rresp [256];
   bit         cfg_rlast_bad;
   int         cfg_aw_delay;
   bit         cfg_wgap;
   bit         cfg_wrdy_rand;
   bit         cfg_rgap;
   int         cfg_rrdy_mode;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
   } ax_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
      bit          last;
   } wb_t;

   ax_t         ax_q[$];
   wb_t         w_q[$];
   logic [63:0] r_q[$];
   logic [1:0]  d_q[$];
   logic [63:0] wbeat_q[$];
   int          done_cnt = 0;
   int          w_cnt = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // Full bus word the slave returns for the word holding address a.
   function automatic logic [63:0] rword(input logic [31:0] a);
      logic [31:0] base;
      logic [63:0] w;
      base = a & ~32'(STRB_W - 1);
      w = '0;
      for (int k = 0; k < STRB_W; k++) w[k*8 +: 8] = mem_byte(base + 32'(k));
      return w;
   endfunction

   // Read data as the requester should see it: bytes from a upward.
   function automatic logic [63:0] exp_rd(input logic [31:0] a);
      int off;
      logic [63:0] w;
      off = int'(a % STRB_W);
      w = '0;
      for (int j = 0; j < STRB_W; j++)
         if (off + j < STRB_W) w[j*8 +: 8] = mem_byte(a + 32'(j));
      return w;
   endfunction

   // Behavioural AXI slave.
   initial begin : slave
      logic s_rst, aw_hs, awv, ar_hs, arv, wl_hs, b_hs, r_hs;
      int aw_cnt, ar_cnt, rbeat;
      logic [31:0] raddr;
      logic [7:0] rlen;
      logic [2:0] rsize;
      bit ractive;
      m_axi_awready = 0; m_axi_arready = 0; m_axi_wready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0;
      m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
      aw_cnt = 0; ar_cnt = 0; rbeat = 0; ractive = 0;
      raddr = 0; rlen = 0; rsize = 0;
      forever begin
         @(negedge i_clk);
         s_rst = i_rst;
         awv   = m_axi_awvalid;
         aw_hs = m_axi_awvalid && m_axi_awready;
         arv   = m_axi_arvalid;
         ar_hs = m_axi_arvalid && m_axi_arready;
         if (ar_hs) begin
            raddr = m_axi_araddr; rlen = m_axi_arlen; rsize = m_axi_arsize;
         end
         wl_hs = m_axi_wvalid && m_axi_wready && m_axi_wlast;
         b_hs  = m_axi_bvalid && m_axi_bready;
         r_hs  = m_axi_rvalid && m_axi_rready;
         @(posedge i_clk);
         #1;
         if (s_rst) begin
            m_axi_awready = 0; m_axi_arready = 0; m_axi_wready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
            aw_cnt = 0; ar_cnt = 0; ractive = 0;
            continue;
         end
         if (aw_hs) begin
            m_axi_awready = 0; aw_cnt = 0;
         end else if (awv) begin
            aw_cnt++; m_axi_awready = (aw_cnt > cfg_aw_delay);
         end
         if (ar_hs) begin
            m_axi_arready = 0; ar_cnt = 0;
         end else if (arv) begin
            ar_cnt++; m_axi_arready = (ar_cnt > cfg_aw_delay);
         end
         m_axi_wready = cfg_wrdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (b_hs) m_axi_bvalid = 0;
         if (wl_hs) begin
            m_axi_bvalid = 1; m_axi_bresp = cfg_bresp;
         end
         if (r_hs) begin
            rbeat++;
            if (rbeat > int'(rlen)) ractive = 0;
         end
         if (ar_hs) begin
            ractive = 1; rbeat = 0;
         end
         if (!(m_axi_rvalid && !r_hs)) begin
            if (ractive && (!cfg_rgap || $urandom_range(0, 2) != 0)) begin
               m_axi_rvalid = 1;
               m_axi_rdata  = rword(raddr + (32'(rbeat) << rsize));
               m_axi_rresp  = cfg_rresp[rbeat];
               m_axi_rlast  = (rbeat == int'(rlen)) && !cfg_rlast_bad;
            end else begin
               m_axi_rvalid = 0;
            end
         end
      end
   end

   // Write-beat source for the internal stream.
   initial begin : wdrv
      logic s_rst, hs;
      i_wvalid = 0; i_wdata = 0;
      forever begin
         @(negedge i_clk);
         s_rst = i_rst;
         hs = i_wvalid && o_wready && !i_rst;
         @(posedge i_clk);
         #1;
         if (s_rst) begin
            i_wvalid = 0;
            continue;
         end
         if (hs && wbeat_q.size() > 0) void'(wbeat_q.pop_front());
         if (wbeat_q.size() > 0 && (!cfg_wgap || $urandom_range(0, 2) != 0)) begin
            i_wvalid = 1; i_wdata = wbeat_q[0];
         end else begin
            i_wvalid = 0;
         end
      end
   end

   // Read-beat consumer readiness.
   initial begin : rdrv
      i_rready = 0;
      forever begin
         @(posedge i_clk);
         #1;
         case (cfg_rrdy_mode)
            0:       i_rready = 1;
            1:       i_rready = 1'($urandom_range(0, 1));
            default: i_rready = ~i_rready;
         endcase
      end
   end

   // Monitor: pops expectations whenever the DUT presents an output.
   initial begin : mon
      bit ax_pend, aw_ok, vw;
      ax_t cur;
      wb_t we;
      logic [52:0] act;
      ax_pend = 0; aw_ok = 0;
      cur = '{0, 0, 0, 0};
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            ax_pend = 0; aw_ok = 0;
            continue;
         end
         if (m_axi_awvalid || m_axi_arvalid) begin
            vw = m_axi_awvalid;
            if (!ax_pend) begin
               if (ax_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL ax_unexpected actual=valid required=no_addr_phase");
                  cur = '{vw, 0, 0, 0};
               end else begin
                  cur = ax_q.pop_front();
               end
               ax_pend = 1;
            end
            act = vw ? {1'b1, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
                        m_axi_awburst, m_axi_awcache, m_axi_awprot}
                     : {1'b0, m_axi_araddr, m_axi_arlen, m_axi_arsize,
                        m_axi_arburst, m_axi_arcache, m_axi_arprot};
            chk("ax_fields", act, {cur.wr, cur.addr, cur.len, cur.size,
                                   2'b01, 4'b0011, 3'b000});
            if ((vw && m_axi_awready) || (!vw && m_axi_arready)) begin
               ax_pend = 0;
               if (vw) aw_ok = 1;
            end
         end
         if (m_axi_wvalid) chk("w_after_aw", aw_ok, 1);
         if (m_axi_wvalid && m_axi_wready) begin
            w_cnt++;
            if (w_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL w_unexpected actual=%0h required=none", m_axi_wdata);
            end else begin
               we = w_q.pop_front();
               chk("wbeat", {m_axi_wdata, m_axi_wstrb, m_axi_wlast},
                   {we.data, we.strb, we.last});
            end
         end
         if (o_rvalid && i_rready) begin
            if (r_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL r_unexpected actual=%0h required=none", o_rdata);
            end else begin
               chk("rdata", o_rdata, r_q.pop_front());
            end
         end
         if (o_done) begin
            done_cnt++;
            aw_ok = 0;
            if (d_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected actual=1 required=0");
            end else begin
               chk("done_err_inv", {o_error, o_invalid}, d_q.pop_front());
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge i_clk);
      #1 i_rst = 1;
      @(posedge i_clk);
      #1 i_rst = 0;
      ax_q.delete(); w_q.delete(); r_q.delete();
      d_q.delete(); wbeat_q.delete();
   endtask

   task automatic idle_chk(input string nm);
      @(negedge i_clk);
      chk(nm, {o_req_ready, o_busy, o_done, o_rvalid, m_axi_awvalid,
               m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready},
          9'b1_0000_0000);
   endtask

   task automatic cfg_default();
      cfg_bresp = 2'b00; cfg_rlast_bad = 0; cfg_aw_delay = 0;
      cfg_wgap = 0; cfg_wrdy_rand = 0; cfg_rgap = 0; cfg_rrdy_mode = 0;
      for (int i = 0; i < 256; i++) cfg_rresp[i] = 2'b00;
   endtask

   task automatic wait_done(input int base);
      int t;
      t = 0;
      while (done_cnt == base && t < 3000) begin
         @(negedge i_clk);
         t++;
      end
      checks++;
      if (done_cnt == base) begin
         errors++;
         $display("FAIL done_timeout actual=no_done required=done");
         do_reset();
      end
   endtask

   // Push expectations from the transfer rules, then present the request.
   task automatic issue(input bit wr, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size,
                        input bit seq, input bit wait_it);
      bit rej;
      int nb, off, base, t;
      logic [1:0] acc;
      logic [31:0] a;
      logic [63:0] d;
      nb = 1 << size;
      rej = (size > 3) || (addr % nb != 0) || (len >= MAX_BEATS)
         || ((addr % 4096) + (len + 1) * nb > 4096);
      if (rej) begin
         d_q.push_back(2'b11);
      end else begin
         ax_q.push_back('{wr, addr, len, size});
         acc = wr ? cfg_bresp : 2'b00;
         for (int b = 0; b <= int'(len); b++) begin
            a = addr + 32'(b * nb);
            off = int'(a % STRB_W);
            if (wr) begin
               d = seq ? 64'(8'hA0 + b) : {$urandom, $urandom};
               wbeat_q.push_back(d);
               w_q.push_back('{d << (off * 8), 8'(((1 << nb) - 1) << off),
                               b == int'(len)});
            end else begin
               if (cfg_rresp[b] > acc) acc = cfg_rresp[b];
               r_q.push_back(exp_rd(a));
            end
         end
         if (!wr && cfg_rlast_bad) acc = 2'b10;
         d_q.push_back({acc != 2'b00, acc == 2'b11});
      end
      base = done_cnt;
      @(posedge i_clk);
      #1;
      i_req_valid = 1; i_req_write = wr; i_req_addr = addr;
      i_req_len = len; i_req_size = size;
      t = 0;
      @(negedge i_clk);
      while (!o_req_ready && t < 100) begin
         @(negedge i_clk);
         t++;
      end
      checks++;
      if (!o_req_ready) begin
         errors++;
         $display("FAIL req_timeout actual=0 required=1");
      end
      @(posedge i_clk);
      #1 i_req_valid = 0;
      if (wait_it) wait_done(base);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      int t, wb;
      bit wr;
      logic [31:0] addr;
      logic [2:0] size;
      i_req_valid = 0; i_req_write = 0; i_req_addr = 0;
      i_req_len = 0; i_req_size = 0;
      cfg_default();
      repeat (3) @(posedge i_clk);
      #1 i_rst = 0;
      idle_chk("reset_state");

      issue(1, 32'h1000, 3, 3, 1, 1);
      idle_chk("idle_after_write");

      cfg_rrdy_mode = 2;
      issue(0, 32'h2002, 2, 1, 0, 1);
      cfg_default();

      issue(0, 32'h0FF8, 1, 3, 0, 1);
      issue(1, 32'h0003, 0, 2, 0, 1);
      issue(0, 32'h0100, 16, 0, 0, 1);

      cfg_rresp[1] = 2'b10;
      issue(0, 32'h5000, 3, 3, 0, 1);
      cfg_default();
      cfg_bresp = 2'b11;
      issue(1, 32'h5100, 1, 2, 0, 1);
      cfg_default();

      cfg_aw_delay = 5; cfg_wgap = 1; cfg_wrdy_rand = 1;
      issue(1, 32'h6010, 7, 2, 0, 1);
      cfg_default();
      cfg_rlast_bad = 1;
      issue(0, 32'h7000, 1, 3, 0, 1);
      cfg_default();

      wb = w_cnt;
      issue(1, 32'h4000, 3, 3, 0, 0);
      t = 0;
      while (w_cnt < wb + 2 && t < 200) begin
         @(negedge i_clk);
         t++;
      end
      chk("reached_beat2", w_cnt >= wb + 2, 1);
      do_reset();
      idle_chk("after_mid_reset");
      issue(0, 32'h4800, 3, 3, 0, 1);

      for (int n = 0; n < 40; n++) begin
         cfg_default();
         wr = 1'($urandom_range(0, 1));
         size = 3'($urandom_range(0, 4));
         addr = $urandom & 32'h0000_FFFF;
         if ($urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << size) - 1);
         cfg_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         for (int i = 0; i < 18; i++)
            cfg_rresp[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         cfg_rlast_bad = ($urandom_range(0, 9) == 0);
         cfg_aw_delay = $urandom_range(0, 3);
         cfg_wgap = 1'($urandom_range(0, 1));
         cfg_wrdy_rand = 1'($urandom_range(0, 1));
         cfg_rgap = 1'($urandom_range(0, 1));
         cfg_rrdy_mode = $urandom_range(0, 2);
         issue(wr, addr, 8'($urandom_range(0, 17)), size, 0, 1);
      end

      repeat (3) @(negedge i_clk);
      chk("queues_empty", {32'(ax_q.size()), 32'(w_q.size()),
                           32'(r_q.size()), 32'(d_q.size())}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
